// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - boot-load / run sequencer for the fetch-stage instruction memory (optional IMEM_CKSUM_EN)
module imem_boot_ctrl #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_req_i,
    input  logic [ADDR_W:0]   load_len_i,
    input  logic              start_run_i,
    input  logic              host_abort_i,
    input  logic              host_valid_i,
    input  logic [DATA_W-1:0] host_data_i,
    output logic              host_ready_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [DATA_W-1:0] imem_din_o,
    output logic              imem_wen_o,
    output logic              load_sel_o,
    output logic              pc_reset_o,
    output logic              rd_en_o,
    output logic              busy_o,
    output logic              err_o
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0]   FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_W:0] DEPTH      = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [FW-1:0]       flush_q;
    logic                host_ready_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [DATA_W-1:0]   imem_din_q;
    logic                imem_wen_q;
    logic                load_sel_q;
    logic                pc_reset_q;
    logic                rd_en_q;
    logic                busy_q;
    logic                err_q;
`ifdef IMEM_CKSUM_EN
    logic [DATA_W-1:0]   sum_q;
`endif

    // Requested length clamped to the memory depth so the address never wraps
    logic [ADDR_W:0] len_clamped_d;
    logic            beat_d;
    logic            load_start_d;

    // Handshake and entry decode shared by the sequencer below
    always_comb begin
        len_clamped_d = (load_len_i > DEPTH) ? DEPTH : load_len_i;
        beat_d        = host_valid_i && host_ready_q;
        load_start_d  = load_req_i && ((state_q == IDLE) || (state_q == RUN));
    end

    // Sequencer: every output is a register so the memory sees stable values at its negedge sample
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            len_q        <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            flush_q      <= '0;
            host_ready_q <= 1'b0;
            imem_addr_q  <= '0;
            imem_din_q   <= '0;
            imem_wen_q   <= 1'b0;
            load_sel_q   <= 1'b0;
            pc_reset_q   <= 1'b0;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef IMEM_CKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            imem_wen_q <= 1'b0;
            if (load_start_d) begin
                state_q      <= LOAD;
                len_q        <= len_clamped_d;
                count_q      <= '0;
                addr_q       <= '0;
                err_q        <= 1'b0;
                load_sel_q   <= 1'b1;
                rd_en_q      <= 1'b0;
                busy_q       <= 1'b1;
`ifdef IMEM_CKSUM_EN
                sum_q        <= '0;
                host_ready_q <= 1'b1;
`else
                host_ready_q <= (len_clamped_d != '0);
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_run_i) begin
                            state_q    <= FLUSH;
                            flush_q    <= '0;
                            pc_reset_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (host_abort_i) begin
                            // Abort beats a same-cycle word: nothing more is written
                            state_q      <= IDLE;
                            err_q        <= 1'b1;
                            host_ready_q <= 1'b0;
                            load_sel_q   <= 1'b0;
                            busy_q       <= 1'b0;
`ifdef IMEM_CKSUM_EN
                        end else if (beat_d && (count_q == len_q)) begin
                            // Trailing checksum word: checked, never written
                            host_ready_q <= 1'b0;
                            load_sel_q   <= 1'b0;
                            if ((sum_q + host_data_i) == '0) begin
                                state_q    <= FLUSH;
                                flush_q    <= '0;
                                pc_reset_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                                err_q   <= 1'b1;
                                busy_q  <= 1'b0;
                            end
`else
                        end else if (count_q == len_q) begin
                            // Only reachable for a zero-length load
                            state_q      <= FLUSH;
                            flush_q      <= '0;
                            pc_reset_q   <= 1'b1;
                            host_ready_q <= 1'b0;
                            load_sel_q   <= 1'b0;
`endif
                        end else if (beat_d) begin
                            imem_addr_q <= addr_q;
                            imem_din_q  <= host_data_i;
                            imem_wen_q  <= 1'b1;
                            addr_q      <= addr_q + 1'b1;
                            count_q     <= count_q + 1'b1;
`ifdef IMEM_CKSUM_EN
                            sum_q       <= sum_q + host_data_i;
`else
                            if ((count_q + 1'b1) == len_q) begin
                                state_q      <= FLUSH;
                                flush_q      <= '0;
                                pc_reset_q   <= 1'b1;
                                host_ready_q <= 1'b0;
                                load_sel_q   <= 1'b0;
                            end
`endif
                        end
                    end
                    FLUSH: begin
                        if (flush_q == FLUSH_LAST) begin
                            state_q    <= RUN;
                            pc_reset_q <= 1'b0;
                            rd_en_q    <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            flush_q <= flush_q + 1'b1;
                        end
                    end
                    default: begin
                        // RUN: fetch owns the memory; only a load request leaves
                    end
                endcase
            end
        end
    end

    assign host_ready_o = host_ready_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_din_o   = imem_din_q;
    assign imem_wen_o   = imem_wen_q;
    assign load_sel_o   = load_sel_q;
    assign pc_reset_o   = pc_reset_q;
    assign rd_en_o      = rd_en_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

endmodule
